// File: rtl/mi_pkg.sv
// Shared types and constants for the audio frame scheduler slice.
package mi_pkg;
   localparam int unsigned SAMPLE_W        = 27;
   localparam int unsigned RAM_DATA_W      = 32;
   localparam int unsigned CLK_DIV_DEFAULT = 1041;
   localparam int unsigned TICK_W          = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_WAIT  = 2'd3
   } sched_state_e;
endpackage

// File: rtl/mi_frame_scheduler_if.sv
// Host parameter-write requester and shared parameter RAM port bundle.
interface mi_frame_scheduler_if
   import mi_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
);
   logic                  host_req;
   logic                  host_we;
   logic [ADDR_W-1:0]     host_addr;
   logic [RAM_DATA_W-1:0] host_wdata;
   logic                  host_gnt;
   logic [ADDR_W-1:0]     ram_addr;
   logic                  ram_we;
   logic [RAM_DATA_W-1:0] ram_wdata;

   modport master (
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, ram_addr, ram_we, ram_wdata
   );

   modport slave (
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, ram_addr, ram_we, ram_wdata
   );
endinterface

// File: rtl/mi_tick_divider.sv
// Frame-rate tick generator: counts 0..CLK_DIV-1 while enabled, held at 0 otherwise.
module mi_tick_divider
   import mi_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);
   logic [TICK_W-1:0] r_count;
   logic              w_last;

   assign w_last = (r_count == TICK_W'(CLK_DIV - 1));
   assign tick   = enable & w_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (!enable || w_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end
endmodule

// File: rtl/mi_frame_scheduler.sv
// Per-frame pipeline sequencer with sample capture, overrun flag and host/pipeline RAM arbitration.
module mi_frame_scheduler
   import mi_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
   parameter int unsigned ADDR_W  = 10
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   output logic                       pipe_start,
   input  logic                       pipe_ready,
   input  logic signed [SAMPLE_W-1:0] pipe_out,
   input  logic [ADDR_W-1:0]          pipe_addr,
   mi_frame_scheduler_if.slave        host,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       sample_valid,
   output logic                       overrun,
   input  logic                       overrun_clr,
   output logic [15:0]                frame_count
);
   sched_state_e               r_state;
   sched_state_e               w_next;
   logic signed [SAMPLE_W-1:0] r_sample;
   logic                       r_valid;
   logic                       r_overrun;
   logic [15:0]                r_frames;
   logic                       w_tick;
   logic                       w_done;
   logic                       w_host_ok;

   mi_tick_divider #(.CLK_DIV(CLK_DIV)) u_tick_divider (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (w_tick)
   );

   assign w_done = (r_state == ST_RUN) && pipe_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_tick) w_next = ST_START;
         ST_START: w_next = ST_RUN;
         ST_RUN:   if (pipe_ready) w_next = ST_WAIT;
         ST_WAIT: begin
            if (w_tick)       w_next = ST_START;
            else if (!enable) w_next = ST_IDLE;
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   // A tick landing while a frame is in flight is dropped and only flagged.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_sample  <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_frames  <= '0;
      end else begin
         r_state <= w_next;
         r_valid <= w_done;
         if (w_done) begin
            r_sample <= pipe_out;
            r_frames <= r_frames + 16'd1;
         end
         if (w_tick && (r_state == ST_START || r_state == ST_RUN)) begin
            r_overrun <= 1'b1;
         end else if (overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign pipe_start   = (r_state == ST_START);
   assign sample_out   = r_sample;
   assign sample_valid = r_valid;
   assign overrun      = r_overrun;
   assign frame_count  = r_frames;

   assign w_host_ok = !reset && host.host_req && !w_tick &&
                      (r_state == ST_IDLE || r_state == ST_WAIT);

   assign host.host_gnt  = w_host_ok;
   assign host.ram_addr  = w_host_ok ? host.host_addr : pipe_addr;
   assign host.ram_we    = w_host_ok & host.host_we;
   assign host.ram_wdata = host.host_wdata;
endmodule

// File: doc/mi_frame_scheduler.md
MI_FRAME_SCHEDULER -- requirements
Module: mi_frame_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1041, meaning clk cycles per audio frame (50 MHz / 48 kHz); legal range 8..65535.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning shared-RAM address width.
REQ-003 SHALL have port clk  in  1  the only clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  run frames while high.
REQ-006 SHALL have port pipe_start  out  1  one-cycle pulse; drives the pipeline reset/start input.
REQ-007 SHALL have port pipe_ready  in  1  pipeline done flag; level signal.
REQ-008 SHALL have port pipe_out  in  27  pipeline output sample, signed.
REQ-009 SHALL have port pipe_addr  in  ADDR_W  pipeline shared-RAM read address.
REQ-010 SHALL have ports host_req, host_we  in  1 each; host_addr  in  ADDR_W; host_wdata  in  32  parameter-write requester.
REQ-011 SHALL have port host_gnt  out  1  high in the cycle the host access is performed.
REQ-012 SHALL have ports ram_addr  out  ADDR_W, ram_we  out  1, ram_wdata  out  32  to the shared parameter RAM.
REQ-013 SHALL have ports sample_out  out  27 (signed) and sample_valid  out  1 (one-cycle pulse).
REQ-014 SHALL have ports overrun  out  1 (sticky) and overrun_clr  in  1.
REQ-015 SHALL have port frame_count  out  16  completed frames, wrapping.

Function
REQ-016 SHALL keep a tick counter 0..CLK_DIV-1 that advances only while enable=1, is held at 0 while enable=0, and asserts an internal tick in the cycle the count equals CLK_DIV-1; the count then wraps to 0.
REQ-017 SHALL implement states IDLE, START, RUN, WAIT.
REQ-018 SHALL transition IDLE/WAIT -> START on tick; START -> RUN unconditionally after 1 cycle; RUN -> WAIT on pipe_ready=1; WAIT -> IDLE when enable=0.
REQ-019 SHALL drive pipe_start=1 in exactly the START cycle, and 0 otherwise.
REQ-020 SHALL evaluate pipe_ready only in RUN; a stale high pipe_ready during START SHALL be ignored.
REQ-021 SHALL, on the RUN->WAIT transition, register sample_out<=pipe_out, pulse sample_valid for 1 cycle, and increment frame_count (0xFFFF wraps to 0).
REQ-022 SHALL set overrun if tick occurs in START or RUN; the tick is dropped and the frame in flight continues.
REQ-023 SHALL clear overrun on overrun_clr; when set and clear occur in the same cycle, set wins.
REQ-024 SHALL, when enable falls mid-frame, complete the current frame (no new START) and then go to IDLE.
REQ-025 SHALL grant the host (host_gnt=1, ram_addr=host_addr, ram_we=host_we, ram_wdata=host_wdata) only when the state is IDLE or WAIT, host_req=1, and no tick occurs that cycle.
REQ-026 SHALL give a tick priority over host_req; the host stays pending and holds its request until host_gnt.
REQ-027 SHALL otherwise drive ram_addr=pipe_addr and ram_we=0.
REQ-028 SHALL not queue host accesses; each granted cycle performs exactly one access.

Reset
REQ-029 SHALL, on reset, set the state to IDLE, the tick counter to 0, pipe_start=0, sample_out=0, sample_valid=0, overrun=0, frame_count=0.
REQ-030 SHALL, on reset asserted mid-frame, abort the frame with no sample_valid and no frame_count increment; host_gnt is 0 during reset.

Structure
REQ-031 SHALL place the state enum, SAMPLE_W=27, RAM_DATA_W=32 and default CLK_DIV in shared package mi_pkg.
REQ-032 SHALL implement the tick counter as sub-module mi_tick_divider (clk, reset, enable, tick).

Verification (CLK_DIV=20)
REQ-033 SHALL cover: enable=1 from reset -> pipe_start pulse at cycle 20; pipe_ready at START+10 with pipe_out=0x0123456 -> sample_valid 1 cycle, sample_out=0x0123456, frame_count=1.
REQ-034 SHALL cover: pipe_ready held high through the next START -> no early completion; the frame completes only when pipe_ready is high in RUN.
REQ-035 SHALL cover: pipe_ready withheld for 25 cycles -> overrun=1 at the tick, no second pipe_start; overrun_clr and a tick in the same cycle -> overrun stays 1.
REQ-036 SHALL cover: host_req write addr 0x005 data 0xDEADBEEF in WAIT -> host_gnt=1, ram_we=1, ram_addr=0x005 the same cycle; a host_req during RUN -> host_gnt=0 until WAIT.
REQ-037 SHALL cover: host_req coincident with tick -> START taken, host_gnt deferred to after the frame ends.
REQ-038 SHALL cover: reset mid-RUN -> all outputs at reset values the next cycle, frame_count unchanged at 0 from a fresh start.
